axi4_blk_regs: RTL and testbench



---
 rtl/axi4_blk_regs.sv | 160 ++++++++++++++++
 tb/tb_axi4_blk_regs.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_blk_regs.sv
// axi4_blk_regs: AXI4-lite slave holding two 32-bit words.
// Word 0 is a control/scratch register exported on ctrl_o.
// Word 1 is a scratch register, or a free-running event counter when the
// build macro AXI4_BLK_REGS_COUNTER_EN is defined. In the counter build,
// the counter advances while ctrl_o[0] is set.
module axi4_blk_regs (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [2:0]  awaddr_i,
    input  logic [2:0]  awprot_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        bvalid_o,
    input  logic        bready_i,
    output logic [1:0]  bresp_o,
    input  logic        arvalid_i,
    output logic        arready_o,
    input  logic [2:0]  araddr_i,
    input  logic [2:0]  arprot_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic [31:0] ctrl_o
);

    logic        aw_held;
    logic        aw_sel;
    logic        w_held;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        bvalid;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] word0;
    logic [31:0] word1;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        commit;
    logic        unused_inputs;

    // Byte-wise merge: strobed bytes take the new data, the rest keep the old value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return result;
    endfunction

    // Channels stall while their beat is held or a write response is pending.
    assign awready_o = ~aw_held & ~bvalid;
    assign wready_o  = ~w_held & ~bvalid;
    assign arready_o = ~rvalid;
    assign aw_hs     = awvalid_i & awready_o;
    assign w_hs      = wvalid_i & wready_o;
    assign ar_hs     = arvalid_i & arready_o;
    assign commit    = aw_held & w_held & ~bvalid;

    assign bvalid_o  = bvalid;
    assign bresp_o   = 2'b00;
    assign rvalid_o  = rvalid;
    assign rdata_o   = rdata;
    assign rresp_o   = 2'b00;
    assign ctrl_o    = word0;

    // Protection bits and sub-word address bits carry no meaning here.
    assign unused_inputs = ^{awprot_i, arprot_i, awaddr_i[1:0], araddr_i[1:0]};

    // Capture AW and W beats independently; both are released by the commit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            aw_held <= 1'b0;
            aw_sel  <= 1'b0;
            w_held  <= 1'b0;
            w_data  <= 32'h0;
            w_strb  <= 4'h0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_sel  <= awaddr_i[2];
            end else if (commit) begin
                aw_held <= 1'b0;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= wdata_i;
                w_strb <= wstrb_i;
            end else if (commit) begin
                w_held <= 1'b0;
            end
        end
    end

    // Write response raised at commit, held until the master accepts it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bvalid <= 1'b0;
        end else if (commit) begin
            bvalid <= 1'b1;
        end else if (bvalid && bready_i) begin
            bvalid <= 1'b0;
        end
    end

    // Word 0: control/scratch register updated by strobed commits.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word0 <= 32'h0;
        end else if (commit && !aw_sel) begin
            word0 <= merge_bytes(word0, w_data, w_strb);
        end
    end

`ifdef AXI4_BLK_REGS_COUNTER_EN
    // Word 1: event counter; a commit loads over the pre-increment value and wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word1 <= 32'h0;
        end else if (commit && aw_sel) begin
            word1 <= merge_bytes(word1, w_data, w_strb);
        end else if (word0[0]) begin
            word1 <= word1 + 32'd1;
        end
    end
`else
    // Word 1: plain scratch register updated by strobed commits.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word1 <= 32'h0;
        end else if (commit && aw_sel) begin
            word1 <= merge_bytes(word1, w_data, w_strb);
        end
    end
`endif

    // Read path: sample the selected word before any same-edge commit lands.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rvalid <= 1'b0;
            rdata  <= 32'h0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= araddr_i[2] ? word1 : word0;
        end else if (rvalid && rready_i) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_blk_regs.sv
// tb_axi4_blk_regs: directed and randomized checks of axi4_blk_regs against a
// two-word behavioural model. Honours AXI4_BLK_REGS_COUNTER_EN like the design.
module tb_axi4_blk_regs;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        awvalid_i = 1'b0;
    logic        awready_o;
    logic [2:0]  awaddr_i = 3'h0;
    logic [2:0]  awprot_i = 3'h0;
    logic        wvalid_i = 1'b0;
    logic        wready_o;
    logic [31:0] wdata_i = 32'h0;
    logic [3:0]  wstrb_i = 4'h0;
    logic        bvalid_o;
    logic        bready_i = 1'b0;
    logic [1:0]  bresp_o;
    logic        arvalid_i = 1'b0;
    logic        arready_o;
    logic [2:0]  araddr_i = 3'h0;
    logic [2:0]  arprot_i = 3'h0;
    logic        rvalid_o;
    logic        rready_i = 1'b0;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic [31:0] ctrl_o;

    int          cyc = 0;
    int          passed = 0;
    int          failed = 0;
    int          total = 0;
    logic [31:0] model [2];

    axi4_blk_regs dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i), .awprot_i(awprot_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
        .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i), .arprot_i(arprot_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
        .ctrl_o(ctrl_o)
    );

    // 100 MHz clock.
    always #5 clk_i = ~clk_i;

    // Edge counter: read #1 after an edge it equals that edge's number.
    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference byte-strobe rule.
    function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                                 input logic [31:0] data,
                                                 input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Full write transaction; commit_edge is the edge at which bvalid_o rose.
    task automatic do_write(input logic addr2, input logic [31:0] data, input logic [3:0] strb,
                            input int bdelay, output int commit_edge);
        int   n;
        logic ag;
        logic wg;
        commit_edge = -1;
        awaddr_i  = {addr2, 2'($urandom_range(0, 3))};
        awprot_i  = 3'($urandom_range(0, 7));
        wdata_i   = data;
        wstrb_i   = strb;
        awvalid_i = 1'b1;
        wvalid_i  = 1'b1;
        n = 0;
        while ((awvalid_i || wvalid_i) && n < 20) begin
            ag = awvalid_i & awready_o;
            wg = wvalid_i & wready_o;
            step();
            if (ag) awvalid_i = 1'b0;
            if (wg) wvalid_i = 1'b0;
            n++;
        end
        if (awvalid_i || wvalid_i) begin
            check_output("write_accept_timeout", 32'd0, 32'd1);
            awvalid_i = 1'b0;
            wvalid_i  = 1'b0;
            return;
        end
        n = 0;
        while (!bvalid_o && n < 20) begin
            step();
            n++;
        end
        if (!bvalid_o) begin
            check_output("bvalid_timeout", 32'd0, 32'd1);
            return;
        end
        commit_edge = cyc;
        model[addr2] = apply_strobe(model[addr2], data, strb);
        check_output("bresp", 32'(bresp_o), 32'd0);
        repeat (bdelay) begin
            step();
            check_output("bvalid_hold", 32'(bvalid_o), 32'd1);
        end
        bready_i = 1'b1;
        step();
        bready_i = 1'b0;
        check_output("bvalid_clear", 32'(bvalid_o), 32'd0);
    endtask

    // Full read transaction; ar_edge is the AR handshake edge.
    task automatic do_read(input logic addr2, input int rdelay,
                           output logic [31:0] data, output int ar_edge);
        int   n;
        logic g;
        data    = 32'hx;
        ar_edge = -1;
        araddr_i  = {addr2, 2'($urandom_range(0, 3))};
        arprot_i  = 3'($urandom_range(0, 7));
        arvalid_i = 1'b1;
        n = 0;
        while (arvalid_i && n < 20) begin
            g = arvalid_i & arready_o;
            step();
            if (g) arvalid_i = 1'b0;
            n++;
        end
        if (arvalid_i) begin
            check_output("read_accept_timeout", 32'd0, 32'd1);
            arvalid_i = 1'b0;
            return;
        end
        ar_edge = cyc;
        check_output("rvalid_set", 32'(rvalid_o), 32'd1);
        check_output("rresp", 32'(rresp_o), 32'd0);
        data = rdata_o;
        repeat (rdelay) begin
            step();
            check_output("rvalid_hold", 32'(rvalid_o), 32'd1);
        end
        rready_i = 1'b1;
        step();
        rready_i = 1'b0;
        check_output("rvalid_clear", 32'(rvalid_o), 32'd0);
    endtask

    // Directed sequence followed by a randomized write/read phase.
    initial begin
        logic [31:0] rd;
        logic [31:0] exp;
        logic [31:0] pre;
        int          e, c, a, w, s;
        logic        addr2;
        logic [31:0] data;
        logic [3:0]  strb;

        model[0] = 32'h0;
        model[1] = 32'h0;

        // Reset values
        #2 rst_n_i = 1'b0;
        step();
        step();
        check_output("rst_awready", 32'(awready_o), 32'd1);
        check_output("rst_wready", 32'(wready_o), 32'd1);
        check_output("rst_arready", 32'(arready_o), 32'd1);
        check_output("rst_bvalid", 32'(bvalid_o), 32'd0);
        check_output("rst_rvalid", 32'(rvalid_o), 32'd0);
        check_output("rst_rdata", rdata_o, 32'h0);
        check_output("rst_ctrl", ctrl_o, 32'h0);
        rst_n_i = 1'b1;
        step();

        // Read both words after reset
        do_read(1'b0, 0, rd, a);
        check_output("reset_read_w0", rd, 32'h0);
        do_read(1'b1, 0, rd, a);
        check_output("reset_read_w1", rd, 32'h0);

`ifdef AXI4_BLK_REGS_COUNTER_EN
        // Counter wraps through zero while ctrl_o[0] is set
        do_write(1'b1, 32'hFFFF_FFFE, 4'hF, 0, e);
        do_write(1'b0, 32'h0000_0001, 4'hF, 0, c);
        check_output("ctrl_run", ctrl_o, 32'h1);
        repeat (3) step();
        do_read(1'b1, 0, rd, a);
        check_output("counter_wrap", rd, 32'hFFFF_FFFE + 32'(a - 1 - c));
        // Partial write during counting wins over the increment
        do_write(1'b1, 32'h1234_5678, 4'b1100, 0, w);
        pre = 32'hFFFF_FFFE + 32'(w - 1 - c);
        exp = {16'h1234, pre[15:0]};
        do_write(1'b0, 32'h0, 4'hF, 0, s);
        exp = exp + 32'(s - w);
        do_read(1'b1, 1, rd, a);
        check_output("counter_load", rd, exp);
        repeat (2) step();
        do_read(1'b1, 0, rd, a);
        check_output("counter_stopped", rd, exp);
        model[0] = 32'h0;
        model[1] = exp;
`else
        // ctrl_o[0] has no effect on the scratch word
        do_write(1'b1, 32'h600D_CAFE, 4'hF, 0, e);
        do_write(1'b0, 32'h0000_0001, 4'hF, 0, c);
        check_output("ctrl_run", ctrl_o, 32'h1);
        repeat (3) step();
        do_read(1'b1, 0, rd, a);
        check_output("scratch_static", rd, 32'h600D_CAFE);
        do_write(1'b0, 32'h0, 4'hF, 0, s);
`endif

        // Byte strobes on word 0
        do_write(1'b0, 32'hA5A5_A5A5, 4'b1111, 0, e);
        check_output("ctrl_full", ctrl_o, 32'hA5A5_A5A5);
        do_write(1'b0, 32'h0000_FF00, 4'b0010, 1, e);
        check_output("ctrl_strobe", ctrl_o, 32'hA5A5_FFA5);
        do_read(1'b0, 0, rd, a);
        check_output("strobe_read", rd, 32'hA5A5_FFA5);

        // W three cycles ahead of AW, B stalled for four cycles
        wdata_i  = 32'hC0DE_0042;
        wstrb_i  = 4'hF;
        wvalid_i = 1'b1;
        check_output("early_w_ready", 32'(wready_o), 32'd1);
        step();
        wvalid_i = 1'b0;
        check_output("early_w_held", 32'(wready_o), 32'd0);
        repeat (2) step();
        check_output("no_commit_without_aw", 32'(bvalid_o), 32'd0);
        awaddr_i  = 3'b000;
        awvalid_i = 1'b1;
        check_output("late_aw_ready", 32'(awready_o), 32'd1);
        step();
        awvalid_i = 1'b0;
        check_output("commit_not_yet", 32'(bvalid_o), 32'd0);
        step();
        check_output("late_commit_bvalid", 32'(bvalid_o), 32'd1);
        check_output("late_commit_ctrl", ctrl_o, 32'hC0DE_0042);
        model[0] = 32'hC0DE_0042;
        awaddr_i  = 3'b100;
        awvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_output("stall_bvalid", 32'(bvalid_o), 32'd1);
            check_output("stall_awready", 32'(awready_o), 32'd0);
            check_output("stall_wready", 32'(wready_o), 32'd0);
            step();
        end
        bready_i = 1'b1;
        step();
        bready_i = 1'b0;
        check_output("b_done_bvalid", 32'(bvalid_o), 32'd0);
        check_output("b_done_awready", 32'(awready_o), 32'd1);
        step();
        awvalid_i = 1'b0;
        check_output("second_aw_held", 32'(awready_o), 32'd0);
        check_output("second_no_commit", 32'(bvalid_o), 32'd0);
        wdata_i  = 32'h5555_AAAA;
        wstrb_i  = 4'hF;
        wvalid_i = 1'b1;
        step();
        wvalid_i = 1'b0;
        step();
        check_output("second_commit", 32'(bvalid_o), 32'd1);
        bready_i = 1'b1;
        step();
        bready_i = 1'b0;
        model[1] = 32'h5555_AAAA;
        do_read(1'b0, 0, rd, a);
        check_output("single_commit_w0", rd, model[0]);
        do_read(1'b1, 0, rd, a);
        check_output("second_write_w1", rd, model[1]);

        // Read and commit to word 0 at the same edge
        awaddr_i  = 3'b000;
        wdata_i   = 32'h0BAD_F00D;
        wstrb_i   = 4'hF;
        awvalid_i = 1'b1;
        wvalid_i  = 1'b1;
        step();
        awvalid_i = 1'b0;
        wvalid_i  = 1'b0;
        araddr_i  = 3'b000;
        arvalid_i = 1'b1;
        check_output("collide_arready", 32'(arready_o), 32'd1);
        step();
        arvalid_i = 1'b0;
        check_output("collide_bvalid", 32'(bvalid_o), 32'd1);
        check_output("collide_rvalid", 32'(rvalid_o), 32'd1);
        check_output("collide_old_value", rdata_o, 32'hC0DE_0042);
        check_output("collide_ctrl", ctrl_o, 32'h0BAD_F00D);
        bready_i = 1'b1;
        rready_i = 1'b1;
        step();
        bready_i = 1'b0;
        rready_i = 1'b0;
        model[0] = 32'h0BAD_F00D;
        do_read(1'b0, 0, rd, a);
        check_output("collide_new_value", rd, 32'h0BAD_F00D);

        // Randomized writes and reads; word 0 bit 0 kept clear so word 1 stays still
        do_write(1'b0, 32'h0, 4'hF, 0, e);
        do_write(1'b1, $urandom, 4'hF, 0, e);
        for (int i = 0; i < 16; i++) begin
            addr2 = 1'($urandom_range(0, 1));
            data  = $urandom;
            strb  = 4'($urandom_range(0, 15));
`ifdef AXI4_BLK_REGS_COUNTER_EN
            if (!addr2) data[0] = 1'b0;
`endif
            do_write(addr2, data, strb, $urandom_range(0, 2), e);
            check_output("rand_ctrl", ctrl_o, model[0]);
            addr2 = 1'($urandom_range(0, 1));
            do_read(addr2, $urandom_range(0, 2), rd, a);
            check_output("rand_read", rd, model[addr2]);
        end

        // Reset with both responses pending: outputs drop without a clock edge
        awaddr_i  = 3'b100;
        wdata_i   = 32'hDEAD_BEEF;
        wstrb_i   = 4'hF;
        araddr_i  = 3'b100;
        awvalid_i = 1'b1;
        wvalid_i  = 1'b1;
        arvalid_i = 1'b1;
        step();
        awvalid_i = 1'b0;
        wvalid_i  = 1'b0;
        arvalid_i = 1'b0;
        step();
        check_output("pre_reset_bvalid", 32'(bvalid_o), 32'd1);
        check_output("pre_reset_rvalid", 32'(rvalid_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check_output("async_bvalid", 32'(bvalid_o), 32'd0);
        check_output("async_rvalid", 32'(rvalid_o), 32'd0);
        check_output("async_rdata", rdata_o, 32'h0);
        check_output("async_ctrl", ctrl_o, 32'h0);
        check_output("async_awready", 32'(awready_o), 32'd1);
        check_output("async_wready", 32'(wready_o), 32'd1);
        check_output("async_arready", 32'(arready_o), 32'd1);
        #2 rst_n_i = 1'b1;
        model[0] = 32'h0;
        model[1] = 32'h0;
        step();
        check_output("post_reset_no_b", 32'(bvalid_o), 32'd0);
        do_read(1'b1, 0, rd, a);
        check_output("post_reset_w1", rd, 32'h0);
        do_read(1'b0, 0, rd, a);
        check_output("post_reset_w0", rd, 32'h0);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
